// File: rtl/division_seq.sv
// rtl/division_seq.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional signed mode (Signed port, Overflow flag) enabled by macro DIVISION_SEQ_SIGNED_EN.
module division_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
`ifdef DIVISION_SEQ_SIGNED_EN
  input  logic         Signed,
`endif
  output logic [W-1:0] Quotient,
  output logic [W-1:0] Remainder,
  output logic         busy,
  output logic         done,
  output logic         DivByZero,
  output logic         Overflow
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [CW-1:0] cnt;

  logic [W:0]    partial;
  logic [W-1:0]  diff;
  logic          fits;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  quo_nx;
  logic          last;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_fix;
  logic [W-1:0]  cap_a;
  logic [W-1:0]  cap_b;

`ifdef DIVISION_SEQ_SIGNED_EN
  logic          neg_q;
  logic          neg_r;
  logic          ovf;
  logic          ovf_cap;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (B == '0) ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = FIN;
      end
      FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One restoring step; the extra top bit of partial keeps the compare exact.
  // When the divisor fits, the true difference is below 2^W, so W-bit wrap is harmless.
  always_comb begin
    partial = {rem, dvd[W-1]};
    fits    = (partial >= {1'b0, dvs});
    diff    = partial[W-1:0] - dvs;
    rem_nx  = fits ? diff : partial[W-1:0];
    quo_nx  = {quo[W-2:0], fits};
    last    = (cnt == CW'(W - 1));
  end

`ifdef DIVISION_SEQ_SIGNED_EN
  always_comb begin
    cap_a   = (Signed && A[W-1]) ? -A : A;
    cap_b   = (Signed && B[W-1]) ? -B : B;
    ovf_cap = Signed && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
    q_fix   = neg_q ? -quo_nx : quo_nx;
    r_fix   = neg_r ? -rem_nx : rem_nx;
  end
`else
  always_comb begin
    cap_a = A;
    cap_b = B;
    q_fix = quo_nx;
    r_fix = rem_nx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
`ifdef DIVISION_SEQ_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd       <= cap_a;
            dvs       <= cap_b;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            DivByZero <= (B == '0);
            Overflow  <= 1'b0;
`ifdef DIVISION_SEQ_SIGNED_EN
            neg_q     <= Signed && (A[W-1] ^ B[W-1]);
            neg_r     <= Signed && A[W-1];
            ovf       <= ovf_cap;
`endif
            // Zero divisor skips RUN, so results land on this same edge into FIN.
            if (B == '0) begin
              Quotient  <= '1;
              Remainder <= A;
            end
          end
        end
        RUN: begin
          dvd <= {dvd[W-2:0], 1'b0};
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            Quotient  <= q_fix;
            Remainder <= r_fix;
`ifdef DIVISION_SEQ_SIGNED_EN
            Overflow  <= ovf;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division_seq.sv
// tb/tb_division_seq.sv - scoreboard bench for division_seq against an arithmetic reference model
// Signed checks are included when DIVISION_SEQ_SIGNED_EN is defined.
module tb_division_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
`ifdef DIVISION_SEQ_SIGNED_EN
  logic         Signed;
`endif
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         busy;
  logic         done;
  logic         DivByZero;
  logic         Overflow;

  division_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
`ifdef DIVISION_SEQ_SIGNED_EN
    .Signed(Signed),
`endif
    .Quotient(Quotient), .Remainder(Remainder), .busy(busy), .done(done),
    .DivByZero(DivByZero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           dc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero for signed operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, input int dc);
    exp_t e;
    int   sa, sb;
    e.dc = dc; e.dbz = 1'b0; e.ovf = 1'b0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(2 ** (W - 1)) && sb == -1) begin
        e.q = {1'b1, {(W-1){1'b0}}}; e.r = '0; e.ovf = 1'b1;
      end else begin
        e.q = W'(sa / sb); e.r = W'(sa % sb);
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) chk("unexpected_done", {31'b0, done}, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.dc);
        chk("quotient", Quotient, e.q);
        chk("remainder", Remainder, e.r);
        chk("divbyzero", DivByZero, e.dbz);
        chk("overflow", Overflow, e.ovf);
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      cycle();
      n++;
      if (n > 200) begin
        chk("idle_timeout", {31'b0, busy}, 0);
        break;
      end
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    wait_idle();
    A = a; B = b; start = 1'b1;
`ifdef DIVISION_SEQ_SIGNED_EN
    Signed = sgn;
`endif
    sbq.push_back(model(a, b, sgn, (b == 0) ? cyc + 1 : cyc + W + 1));
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    issue(a, b, sgn);
    cycle();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rs;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
`ifdef DIVISION_SEQ_SIGNED_EN
    Signed = 1'b0;
`endif
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_quotient", Quotient, 0);
    chk("rst_remainder", Remainder, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_dbz", {31'b0, DivByZero}, 0);
    chk("rst_ovf", {31'b0, Overflow}, 0);

    // 100/7: busy cycles 1..W+1, done only in cycle W+1
    issue(16'd100, 16'd7, 1'b0);
    for (int k = 1; k <= W + 2; k++) begin
      cycle();
      start = 1'b0;
      chk("lat_busy", {31'b0, busy}, {31'b0, (k <= W + 1)});
      chk("lat_done", {31'b0, done}, {31'b0, (k == W + 1)});
    end

    // divide by zero: done and busy in cycle 1 only
    issue(16'd1234, 16'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      start = 1'b0;
      chk("dbz_busy", {31'b0, busy}, {31'b0, (k == 1)});
      chk("dbz_done", {31'b0, done}, {31'b0, (k == 1)});
    end

    // back-to-back: start held through FIN is taken only in the following IDLE cycle
    run(16'hFFFF, 16'd1, 1'b0);
    n = 0;
    while (!done && n < 40) begin cycle(); n++; end
    chk("b2b_done_seen", {31'b0, done}, 1);
    A = 16'd5; B = 16'd9; start = 1'b1;
    cycle();
    sbq.push_back(model(16'd5, 16'd9, 1'b0, cyc + W + 1));
    cycle();
    start = 1'b0;

    // operand changes and a start pulse during RUN have no effect
    run(16'd100, 16'd7, 1'b0);
    n = cyc - 1;
    while (cyc < n + 5) cycle();
    A = 16'd9; B = 16'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_idle();
    cycle();

    // reset mid-run: outputs cleared, no done pulse afterwards
    wait_idle();
    A = 16'd100; B = 16'd7; start = 1'b1; n = cyc;
    cycle();
    start = 1'b0;
    while (cyc < n + 8) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_quotient", Quotient, 0);
    chk("midrst_remainder", Remainder, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_dbz", {31'b0, DivByZero}, 0);
    repeat (W + 4) cycle();

`ifdef DIVISION_SEQ_SIGNED_EN
    run(16'hFFF9, 16'd2, 1'b1);
    run(16'h8000, 16'hFFFF, 1'b1);
    run(16'hFFF9, 16'd2, 1'b0);
    run(16'hFFF9, 16'd0, 1'b1);
`endif

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
`ifdef DIVISION_SEQ_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run(ra, rb, rs);
      repeat ($urandom_range(0, 3)) cycle();
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin cycle(); n++; end
    chk("drain_pending", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
